// File: rtl/cache_axi_bridge.sv
// rtl/cache_axi_bridge.sv - ICache/DCache to AXI3 master bridge with independent read and write engines
module cache_axi_bridge #(
  parameter int         LINE_WORDS = 4,
  parameter logic [3:0] ICACHE_ID  = 4'd0,
  parameter logic [3:0] DCACHE_ID  = 4'd1
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       icache_rd_req,
  input  logic [2:0]                 icache_rd_type,
  input  logic [31:0]                icache_rd_addr,
  output logic                       icache_rd_rdy,
  output logic                       icache_ret_valid,
  output logic                       icache_ret_last,
  output logic [31:0]                icache_ret_data,
  input  logic                       dcache_rd_req,
  input  logic [2:0]                 dcache_rd_type,
  input  logic [31:0]                dcache_rd_addr,
  output logic                       dcache_rd_rdy,
  output logic                       dcache_ret_valid,
  output logic                       dcache_ret_last,
  output logic [31:0]                dcache_ret_data,
  input  logic                       dcache_wr_req,
  input  logic [2:0]                 dcache_wr_type,
  input  logic [31:0]                dcache_wr_addr,
  input  logic [3:0]                 dcache_wr_wstrb,
  input  logic [32*LINE_WORDS-1:0]   dcache_wr_data,
  output logic                       dcache_wr_rdy,
  output logic [3:0]                 arid,
  output logic [31:0]                araddr,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [3:0]                 rid,
  input  logic [31:0]                rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready,
  output logic [3:0]                 awid,
  output logic [31:0]                awaddr,
  output logic [7:0]                 awlen,
  output logic [2:0]                 awsize,
  output logic [1:0]                 awburst,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [3:0]                 wid,
  output logic [31:0]                wdata,
  output logic [3:0]                 wstrb,
  output logic                       wlast,
  output logic                       wvalid,
  input  logic                       wready,
  input  logic [3:0]                 bid,
  input  logic [1:0]                 bresp,
  input  logic                       bvalid,
  output logic                       bready,
  output logic [1:0]                 arlock,
  output logic [3:0]                 arcache,
  output logic [2:0]                 arprot,
  output logic [1:0]                 awlock,
  output logic [3:0]                 awcache,
  output logic [2:0]                 awprot
);

  localparam int L  = $clog2(LINE_WORDS * 4);
  localparam int CW = $clog2(LINE_WORDS);

  // Request type to AXI size: line and word are 4 bytes, half 2, byte 1
  function automatic logic [2:0] size_of(input logic [2:0] t);
    if (t[2] || t == 3'b010) return 3'd2;
    else if (t == 3'b001)    return 3'd1;
    else                     return 3'd0;
  endfunction

  typedef enum logic [1:0] {RIDLE, RAR, RDATA} rd_state_t;
  typedef enum logic [1:0] {WIDLE, WSEND, WRESP} wr_state_t;

  rd_state_t rd_state;
  wr_state_t wr_state;

  logic gnt_d;   // DCache owns the read engine
  logic last_d;  // DCache won the most recent grant

  logic [31:0]               wr_addr_q;
  logic [2:0]                wr_type_q;
  logic [3:0]                wr_strb_q;
  logic [32*LINE_WORDS-1:0]  wr_data_q;
  logic [CW-1:0]             wr_last_idx;
  logic [CW-1:0]             wr_cnt;
  logic                      aw_done;
  logic                      w_done;

  logic       wr_busy, hazard, d_elig, pick_d;
  logic       aw_hs, w_hs;
  logic [2:0] ar_type;
  logic       unused_ok;

  // A DCache read may not overtake a write to the same line, in flight or arriving now
  assign wr_busy = (wr_state != WIDLE);
  assign hazard  = (wr_busy && dcache_rd_addr[31:L] == wr_addr_q[31:L]) ||
                   (dcache_wr_req && dcache_wr_rdy &&
                    dcache_rd_addr[31:L] == dcache_wr_addr[31:L]);
  assign d_elig  = dcache_rd_req && !hazard;
  assign pick_d  = d_elig && (!icache_rd_req || !last_d);

  // Read engine: round-robin grant, AR issue, then R beats until rlast
  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_state <= RIDLE;
      gnt_d    <= 1'b0;
      last_d   <= 1'b1;
    end else begin
      case (rd_state)
        RIDLE: if (icache_rd_req || d_elig) begin
          gnt_d    <= pick_d;
          last_d   <= pick_d;
          rd_state <= RAR;
        end
        RAR:   if (arready) rd_state <= RDATA;
        RDATA: if (rvalid && rlast) rd_state <= RIDLE;
        default: rd_state <= RIDLE;
      endcase
    end
  end

  assign ar_type          = gnt_d ? dcache_rd_type : icache_rd_type;
  assign arvalid          = (rd_state == RAR);
  assign araddr           = gnt_d ? dcache_rd_addr : icache_rd_addr;
  assign arlen            = ar_type[2] ? 8'(LINE_WORDS - 1) : 8'd0;
  assign arsize           = size_of(ar_type);
  assign arburst          = 2'b01;
  assign arid             = gnt_d ? DCACHE_ID : ICACHE_ID;
  assign icache_rd_rdy    = arvalid && arready && !gnt_d;
  assign dcache_rd_rdy    = arvalid && arready && gnt_d;
  assign rready           = (rd_state == RDATA);
  assign icache_ret_valid = rready && rvalid && !gnt_d;
  assign icache_ret_last  = icache_ret_valid && rlast;
  assign icache_ret_data  = rdata;
  assign dcache_ret_valid = rready && rvalid && gnt_d;
  assign dcache_ret_last  = dcache_ret_valid && rlast;
  assign dcache_ret_data  = rdata;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // Write engine: latch the request, run AW and W independently, then wait for B
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state    <= WIDLE;
      wr_addr_q   <= '0;
      wr_type_q   <= '0;
      wr_strb_q   <= '0;
      wr_data_q   <= '0;
      wr_last_idx <= '0;
      wr_cnt      <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
    end else begin
      case (wr_state)
        WIDLE: if (dcache_wr_req) begin
          wr_addr_q   <= dcache_wr_addr;
          wr_type_q   <= dcache_wr_type;
          wr_strb_q   <= dcache_wr_wstrb;
          wr_data_q   <= dcache_wr_data;
          wr_last_idx <= dcache_wr_type[2] ? CW'(LINE_WORDS - 1) : '0;
          wr_cnt      <= '0;
          aw_done     <= 1'b0;
          w_done      <= 1'b0;
          wr_state    <= WSEND;
        end
        WSEND: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs) begin
            if (wlast) w_done <= 1'b1;
            else       wr_cnt <= wr_cnt + 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || (w_hs && wlast))) wr_state <= WRESP;
        end
        WRESP: if (bvalid) wr_state <= WIDLE;
        default: wr_state <= WIDLE;
      endcase
    end
  end

  assign dcache_wr_rdy = (wr_state == WIDLE);
  assign awvalid       = (wr_state == WSEND) && !aw_done;
  assign wvalid        = (wr_state == WSEND) && !w_done;
  assign awid          = DCACHE_ID;
  assign awaddr        = wr_addr_q;
  assign awlen         = 8'(wr_last_idx);
  assign awsize        = size_of(wr_type_q);
  assign awburst       = 2'b01;
  assign wid           = DCACHE_ID;
  assign wdata         = wr_data_q[32*wr_cnt +: 32];
  assign wstrb         = wr_type_q[2] ? 4'hF : wr_strb_q;
  assign wlast         = (wr_cnt == wr_last_idx);
  assign bready        = (wr_state == WRESP);

  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  // Response IDs and status are not acted on by this bridge
  assign unused_ok = ^{rid, rresp, bid, bresp};

endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb/tb_cache_axi_bridge.sv - directed self-checking bench for cache_axi_bridge
module tb_cache_axi_bridge;

  logic         aclk = 1'b0;
  logic         areset;
  logic         icache_rd_req;
  logic [2:0]   icache_rd_type;
  logic [31:0]  icache_rd_addr;
  logic         icache_rd_rdy, icache_ret_valid, icache_ret_last;
  logic [31:0]  icache_ret_data;
  logic         dcache_rd_req;
  logic [2:0]   dcache_rd_type;
  logic [31:0]  dcache_rd_addr;
  logic         dcache_rd_rdy, dcache_ret_valid, dcache_ret_last;
  logic [31:0]  dcache_ret_data;
  logic         dcache_wr_req;
  logic [2:0]   dcache_wr_type;
  logic [31:0]  dcache_wr_addr;
  logic [3:0]   dcache_wr_wstrb;
  logic [127:0] dcache_wr_data;
  logic         dcache_wr_rdy;
  logic [3:0]   arid, awid, wid, rid, bid;
  logic [31:0]  araddr, awaddr, wdata, rdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize, arprot, awprot;
  logic [1:0]   arburst, awburst, rresp, bresp, arlock, awlock;
  logic [3:0]   arcache, awcache, wstrb;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int total = 0;
  int bad   = 0;

  cache_axi_bridge #(.LINE_WORDS(4), .ICACHE_ID(4'd0), .DCACHE_ID(4'd1)) dut (
    .aclk(aclk), .areset(areset),
    .icache_rd_req(icache_rd_req), .icache_rd_type(icache_rd_type), .icache_rd_addr(icache_rd_addr),
    .icache_rd_rdy(icache_rd_rdy), .icache_ret_valid(icache_ret_valid), .icache_ret_last(icache_ret_last),
    .icache_ret_data(icache_ret_data),
    .dcache_rd_req(dcache_rd_req), .dcache_rd_type(dcache_rd_type), .dcache_rd_addr(dcache_rd_addr),
    .dcache_rd_rdy(dcache_rd_rdy), .dcache_ret_valid(dcache_ret_valid), .dcache_ret_last(dcache_ret_last),
    .dcache_ret_data(dcache_ret_data),
    .dcache_wr_req(dcache_wr_req), .dcache_wr_type(dcache_wr_type), .dcache_wr_addr(dcache_wr_addr),
    .dcache_wr_wstrb(dcache_wr_wstrb), .dcache_wr_data(dcache_wr_data), .dcache_wr_rdy(dcache_wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .awlock(awlock), .awcache(awcache), .awprot(awprot)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serve one read: wait for AR, check its fields, accept it, return beats d0, d0+1, ...
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input int beats, input logic [31:0] d0,
                          input logic [1:0] drop);
    int n = 0;
    while (!arvalid && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check("ar_seen", arvalid, 1);
    check("arid", arid, id);
    check("araddr", araddr, addr);
    check("arlen", arlen, len);
    check("arsize", arsize, size);
    check("arburst", arburst, 2'b01);
    arready = 1'b1;
    #1;
    check("rd_rdy_own", (id == 4'd0) ? icache_rd_rdy : dcache_rd_rdy, 1);
    check("rd_rdy_other", (id == 4'd0) ? dcache_rd_rdy : icache_rd_rdy, 0);
    @(negedge aclk);
    arready = 1'b0;
    if (drop[0]) icache_rd_req = 1'b0;
    if (drop[1]) dcache_rd_req = 1'b0;
    for (int i = 0; i < beats; i++) begin
      rvalid = 1'b1;
      rid    = id;
      rdata  = d0 + i;
      rlast  = (i == beats - 1);
      #1;
      check("rready", rready, 1);
      check("ret_valid", (id == 4'd0) ? icache_ret_valid : dcache_ret_valid, 1);
      check("ret_data", (id == 4'd0) ? icache_ret_data : dcache_ret_data, d0 + i);
      check("ret_last", (id == 4'd0) ? icache_ret_last : dcache_ret_last, (i == beats - 1));
      check("ret_other", (id == 4'd0) ? dcache_ret_valid : icache_ret_valid, 0);
      @(negedge aclk);
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    areset = 1'b1;
    icache_rd_req = 0; icache_rd_type = 3'b010; icache_rd_addr = 0;
    dcache_rd_req = 0; dcache_rd_type = 3'b010; dcache_rd_addr = 0;
    dcache_wr_req = 0; dcache_wr_type = 3'b100; dcache_wr_addr = 0;
    dcache_wr_wstrb = 0; dcache_wr_data = '0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 4'd1; bresp = 0; bvalid = 0;
    repeat (3) @(negedge aclk);

    // Reset state
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_iret", icache_ret_valid, 0);
    check("rst_dret", dcache_ret_valid, 0);
    check("rst_wr_rdy", dcache_wr_rdy, 1);
    areset = 1'b0;
    @(negedge aclk);

    // Both read ports held: grants alternate I, D, I starting with ICache
    icache_rd_req = 1; icache_rd_type = 3'b010; icache_rd_addr = 32'h0000_0100;
    dcache_rd_req = 1; dcache_rd_type = 3'b010; dcache_rd_addr = 32'h0000_0200;
    axi_read(4'd0, 32'h0000_0100, 8'd0, 3'd2, 1, 32'h10, 2'b00);
    axi_read(4'd1, 32'h0000_0200, 8'd0, 3'd2, 1, 32'h20, 2'b00);
    axi_read(4'd0, 32'h0000_0100, 8'd0, 3'd2, 1, 32'h30, 2'b11);
    @(negedge aclk);
    check("arb_idle", arvalid, 0);

    // ICache line read
    icache_rd_req = 1; icache_rd_type = 3'b100; icache_rd_addr = 32'h1C00_0040;
    axi_read(4'd0, 32'h1C00_0040, 8'd3, 3'd2, 4, 32'hA0, 2'b01);
    check("line_rd_done_rready", rready, 0);
    check("line_rd_done_arvalid", arvalid, 0);

    // DCache line write, AW before W, wready low two cycles
    check("wr_rdy_before", dcache_wr_rdy, 1);
    dcache_wr_req = 1; dcache_wr_type = 3'b100; dcache_wr_addr = 32'h0000_1000;
    dcache_wr_wstrb = 4'h0;
    dcache_wr_data = {32'h44, 32'h33, 32'h22, 32'h11};
    @(negedge aclk);
    dcache_wr_req = 0;
    check("wl_awvalid", awvalid, 1);
    check("wl_awaddr", awaddr, 32'h0000_1000);
    check("wl_awlen", awlen, 8'd3);
    check("wl_awsize", awsize, 3'd2);
    check("wl_awid", awid, 4'd1);
    check("wl_wvalid", wvalid, 1);
    check("wl_wr_rdy_busy", dcache_wr_rdy, 0);
    awready = 1;
    @(negedge aclk);
    awready = 0;
    check("wl_aw_done", awvalid, 0);
    check("wl_w_waiting", wvalid, 1);
    @(negedge aclk);
    wready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("wl_wvalid_beat", wvalid, 1);
      check("wl_wdata", wdata, 32'h11 * (i + 1));
      check("wl_wstrb", wstrb, 4'hF);
      check("wl_wlast", wlast, (i == 3));
      @(negedge aclk);
    end
    wready = 0;
    check("wl_w_done", wvalid, 0);
    check("wl_bready", bready, 1);
    bvalid = 1;
    #1;
    check("wl_wr_rdy_during_b", dcache_wr_rdy, 0);
    @(negedge aclk);
    bvalid = 0;
    check("wl_wr_rdy_after_b", dcache_wr_rdy, 1);

    // Hazard: DCache read to a line being written waits for B; ICache proceeds
    dcache_wr_req = 1; dcache_wr_type = 3'b100; dcache_wr_addr = 32'h0000_1000;
    dcache_rd_req = 1; dcache_rd_type = 3'b010; dcache_rd_addr = 32'h0000_1008;
    icache_rd_req = 1; icache_rd_type = 3'b010; icache_rd_addr = 32'h0000_0300;
    @(negedge aclk);
    dcache_wr_req = 0;
    axi_read(4'd0, 32'h0000_0300, 8'd0, 3'd2, 1, 32'hB0, 2'b01);
    for (int i = 0; i < 3; i++) begin
      check("hz_held", arvalid, 0);
      @(negedge aclk);
    end
    awready = 1; wready = 1;
    n = 0;
    while (!bready && n < 20) begin
      @(negedge aclk);
      n++;
    end
    awready = 0; wready = 0;
    check("hz_bready", bready, 1);
    check("hz_held_at_b", arvalid, 0);
    bvalid = 1;
    @(negedge aclk);
    bvalid = 0;
    check("hz_held_after_b", arvalid, 0);
    axi_read(4'd1, 32'h0000_1008, 8'd0, 3'd2, 1, 32'hC0, 2'b10);

    // Single-byte write
    dcache_wr_req = 1; dcache_wr_type = 3'b000; dcache_wr_addr = 32'h0000_2003;
    dcache_wr_wstrb = 4'b1000; dcache_wr_data[31:0] = 32'hDEAD_BEEF;
    @(negedge aclk);
    dcache_wr_req = 0;
    check("bw_awaddr", awaddr, 32'h0000_2003);
    check("bw_awlen", awlen, 8'd0);
    check("bw_awsize", awsize, 3'd0);
    check("bw_wstrb", wstrb, 4'b1000);
    check("bw_wlast", wlast, 1);
    check("bw_wdata", wdata, 32'hDEAD_BEEF);
    awready = 1; wready = 1;
    @(negedge aclk);
    awready = 0; wready = 0;
    check("bw_bready", bready, 1);
    check("bw_wvalid_done", wvalid, 0);
    bvalid = 1;
    @(negedge aclk);
    bvalid = 0;
    check("bw_wr_rdy", dcache_wr_rdy, 1);

    // Reset during beat 2 of a line read, with a write also in flight
    dcache_wr_req = 1; dcache_wr_type = 3'b100; dcache_wr_addr = 32'h0000_3000;
    icache_rd_req = 1; icache_rd_type = 3'b100; icache_rd_addr = 32'h0000_0040;
    @(negedge aclk);
    dcache_wr_req = 0;
    check("rs_arvalid", arvalid, 1);
    arready = 1;
    @(negedge aclk);
    arready = 0; icache_rd_req = 0;
    rvalid = 1; rdata = 32'hD0; rlast = 0;
    @(negedge aclk);
    rdata = 32'hD1;
    areset = 1;
    @(negedge aclk);
    check("rs_arvalid_off", arvalid, 0);
    check("rs_rready_off", rready, 0);
    check("rs_iret_off", icache_ret_valid, 0);
    check("rs_wr_rdy", dcache_wr_rdy, 1);
    check("rs_awvalid_off", awvalid, 0);
    check("rs_wvalid_off", wvalid, 0);
    areset = 0; rvalid = 0;
    dcache_rd_req = 1; dcache_rd_type = 3'b010; dcache_rd_addr = 32'h0000_5000;
    axi_read(4'd1, 32'h0000_5000, 8'd0, 3'd2, 1, 32'hE0, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_axi_bridge.md
Name: cache_axi_bridge

Overview:
- Next-generation cache-to-AXI bridge: one ICache read port, one DCache read port and one DCache write port onto a single AXI3 master.
- Independent read and write engines, so one read and one write can be outstanding at once.
- Read requests use round-robin arbitration. Writes support line-size bursts (DCache write-back). A DCache read to a line with a pending write is held until that write's B response.
- Sits between the cache pair and the SoC AXI interconnect.

Parameters:
LINE_WORDS, 4, 32-bit words per cache line; power of two, 2..16.
ICACHE_ID, 0, 4-bit ARID for ICache reads.
DCACHE_ID, 1, 4-bit ARID for DCache reads and AWID/WID for writes.

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
icache_rd_req  in  1  ICache read request; addr/type held until icache_rd_rdy
icache_rd_type  in  3  000 byte, 001 half, 010 word, 100 line
icache_rd_addr  in  32  read address
icache_rd_rdy  out  1  request accepted (equals AR handshake for ICache)
icache_ret_valid  out  1  return beat valid
icache_ret_last  out  1  final return beat
icache_ret_data  out  32  return data
dcache_rd_req/_type/_addr/_rdy  in/in/in/out  1/3/32/1  DCache read port, same rules as ICache
dcache_ret_valid/_last/_data  out  1/1/32  DCache return port
dcache_wr_req  in  1  write request
dcache_wr_type  in  3  000/001/010 single beat, 100 line burst
dcache_wr_addr  in  32  write address (line-aligned for type 100)
dcache_wr_wstrb  in  4  byte strobes, single-beat writes only
dcache_wr_data  in  32*LINE_WORDS  write data; word i = bits [32i+31:32i]; single beat uses word 0
dcache_wr_rdy  out  1  write port free
arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/8/3/2/1  AR channel
arready  in  1  AR ready
rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  R channel
rready  out  1  R ready
awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/8/3/2/1  AW channel
awready  in  1  AW ready
wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  W channel
wready  in  1  W ready
bid/bresp/bvalid  in  4/2/1  B channel
bready  out  1  B ready
arlock/arcache/arprot/awlock/awcache/awprot  out  2/4/3/2/4/3  tied 0

Behaviour:
- Reset: both engines idle. All valid/ready/rdy/ret outputs are 0 except dcache_wr_rdy=1. Round-robin pointer is 1 (ICache wins the first tie). Any in-flight AXI transaction is abandoned.
- Read FSM RIDLE->RAR->RDATA->RIDLE.
  - RIDLE: eligible = icache_rd_req, dcache_rd_req && !hazard.
  - One eligible: grant it. Both eligible: grant the port not granted last. Grant is registered; go to RAR.
  - RAR: arvalid=1. Fields are driven combinationally from the granted port's inputs.
  - arlen = LINE_WORDS-1 for type 100, else 0. arsize = 2 for types 100/010, 1 for 001, 0 for 000. arburst = 01. arid = granted ID.
  - Granted port's rd_rdy = arvalid && arready. On that handshake go to RDATA.
  - RDATA: rready=1. Granted port: ret_valid = rvalid, ret_data = rdata, ret_last = rvalid && rlast. The other port's ret_valid stays 0.
  - rvalid && rlast -> RIDLE; the next grant is possible the following cycle. rresp is ignored.
- hazard = (wr engine busy && dcache_rd_addr[31:L] == latched wr line) || (dcache_wr_req && dcache_wr_rdy && dcache_rd_addr[31:L] == dcache_wr_addr[31:L]), where L = log2(LINE_WORDS*4). A same-cycle write therefore wins over a same-line read.
- Write FSM WIDLE->WSEND->WRESP->WIDLE.
  - dcache_wr_rdy = (state==WIDLE). On dcache_wr_req && dcache_wr_rdy, latch addr, type, wstrb and the full data line; beats = LINE_WORDS for 100, else 1.
  - WSEND: awvalid until AW handshake. wvalid until the last W handshake. AW and W are independent and either may complete first.
  - wdata = latched word[cnt]; cnt increments on each W handshake and never exceeds beats-1. wlast = (cnt == beats-1).
  - wstrb = 4'hF for bursts, latched strobe otherwise. awlen = beats-1; awsize per read rule.
  - When AW done and the last W done (including same-cycle completion) -> WRESP. WRESP: bready=1; on bvalid -> WIDLE.
- Read and write engines run concurrently with no interaction except the hazard.
- areset asserted mid-burst returns both FSMs to idle the next cycle regardless of AXI state.

Test Plan:
- ICache line read at 0x1C000040, memory returns 4 beats 0xA0..0xA3 -> arlen=3, arsize=2, arid=0. icache_ret_valid on 4 cycles; icache_ret_last only with 0xA3; dcache_ret_valid stays 0.
- ICache and DCache read requests held together for 3 transactions -> grants ICache, DCache, ICache, with arid sequence 0, 1, 0.
- DCache line write to 0x00001000, data words 0x11..0x44, wready low 2 cycles, AW accepted before W -> 4 W beats in order, wstrb=F, wlast only on 0x44. dcache_wr_rdy returns to 1 the cycle after the bvalid handshake.
- DCache read 0x00001008 while the 0x00001000 line write is pending, plus a concurrent ICache read -> ICache read proceeds. DCache arvalid only after B handshake.
- Single-byte write 0x00002003, wstrb=1000 -> awlen=0, awsize=0, wstrb=1000, wlast=1 on the single beat.
- areset during beat 2 of a line read -> next cycle arvalid=rready=0, ret_valid=0, dcache_wr_rdy=1. A new read is then accepted normally.
